lag_tile_link_scheduler: RTL and testbench

LAG_TILE_LINK_SCHEDULER -- requirements
Module: lag_tile_link_scheduler

---
 rtl/lag_tile_link_scheduler.sv | 168 ++++++++++++++++
 tb/tb_lag_tile_link_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_tile_link_scheduler.sv
// Tile injection scheduler: binds traffic sources to LAG links for whole
// packets, round-robin over the sources, with per-link credit flow control.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | link free, can be granted to an unbound requesting source
//   BUSY  | link owned by owner_q until that source's tail flit leaves
module lag_tile_link_scheduler #(
    parameter int NREQ    = 4,
    parameter int NLINKS  = 2,
    parameter int CREDITS = 4,
    parameter int FLIT_W  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_tail,
    input  logic [NREQ-1:0][FLIT_W-1:0]     req_data,
    output logic [NREQ-1:0]                 req_ready,
    output logic [NLINKS-1:0]               link_valid,
    output logic [NLINKS-1:0]               link_tail,
    output logic [NLINKS-1:0][FLIT_W-1:0]   link_data,
    input  logic [NLINKS-1:0]               credit_in,
    output logic [NLINKS-1:0]               link_busy,
    output logic                            credit_err
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} link_state_t;

    link_state_t                        state_q [NLINKS];
    link_state_t                        state_d [NLINKS];
    logic [NLINKS-1:0][OW-1:0]          owner_q, owner_d;
    logic [NLINKS-1:0][CW-1:0]          credit_q, credit_d;
    logic [OW-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [NLINKS-1:0]                  link_valid_q, link_valid_d;
    logic [NLINKS-1:0]                  link_tail_q, link_tail_d;
    logic [NLINKS-1:0][FLIT_W-1:0]      link_data_q, link_data_d;
    logic                               credit_err_q, credit_err_d;

    logic [NREQ-1:0]                    bound;
    logic [NREQ-1:0]                    cand;
    logic [NLINKS-1:0]                  xfer;
    logic [NLINKS-1:0]                  grant_onehot;
    logic [OW-1:0]                      win_src;
    logic                               found_src;
    logic                               found_link;

    // Per-link ownership map and transfer qualification; nothing moves in reset.
    always_comb begin
        bound = '0;
        xfer  = '0;
        for (int l = 0; l < NLINKS; l++) begin
            if (state_q[l] == ST_BUSY) begin
                bound[owner_q[l]] = 1'b1;
                xfer[l] = rst_n && (credit_q[l] != '0) && req_valid[owner_q[l]];
            end
        end
    end

    // Round-robin pick among unbound requesters; winner takes the lowest idle link.
    always_comb begin
        cand         = req_valid & ~bound;
        found_src    = 1'b0;
        win_src      = '0;
        found_link   = 1'b0;
        grant_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_src && cand[OW'((int'(rr_ptr_q) + k) % NREQ)]) begin
                found_src = 1'b1;
                win_src   = OW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
        for (int l = 0; l < NLINKS; l++) begin
            if (!found_link && state_q[l] == ST_IDLE) begin
                found_link      = 1'b1;
                grant_onehot[l] = found_src && rst_n;
            end
        end
        rr_ptr_d = (|grant_onehot) ? OW'((int'(win_src) + 1) % NREQ) : rr_ptr_q;
    end

    // Link FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < NLINKS; l++) state_q[l] <= ST_IDLE;
            owner_q <= '0;
        end else begin
            for (int l = 0; l < NLINKS; l++) state_q[l] <= state_d[l];
            owner_q <= owner_d;
        end
    end

    // Link FSM next state: bind on grant, release after the tail flit transfers.
    always_comb begin
        for (int l = 0; l < NLINKS; l++) begin
            state_d[l] = state_q[l];
            owner_d[l] = owner_q[l];
            case (state_q[l])
                ST_IDLE: begin
                    if (grant_onehot[l]) begin
                        state_d[l] = ST_BUSY;
                        owner_d[l] = win_src;
                    end
                end
                ST_BUSY: begin
                    if (xfer[l] && req_tail[owner_q[l]]) state_d[l] = ST_IDLE;
                end
                default: state_d[l] = ST_IDLE;
            endcase
        end
    end

    // Link FSM outputs: busy flag and combinational ready back to the owner.
    always_comb begin
        link_busy = '0;
        req_ready = '0;
        for (int l = 0; l < NLINKS; l++) begin
            link_busy[l] = (state_q[l] == ST_BUSY);
            if (xfer[l]) req_ready[owner_q[l]] = 1'b1;
        end
    end

    // Output flit staging and credit accounting; overflow saturates and sticks.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int l = 0; l < NLINKS; l++) begin
            link_valid_d[l] = xfer[l];
            link_tail_d[l]  = xfer[l] && req_tail[owner_q[l]];
            link_data_d[l]  = xfer[l] ? req_data[owner_q[l]] : link_data_q[l];
            credit_d[l]     = credit_q[l];
            if (xfer[l] && !credit_in[l]) begin
                credit_d[l] = credit_q[l] - CW'(1);
            end else if (!xfer[l] && credit_in[l]) begin
                if (credit_q[l] == CRED_MAX) credit_err_d = 1'b1;
                else                         credit_d[l] = credit_q[l] + CW'(1);
            end
        end
    end

    // Datapath, credit and arbitration pointer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < NLINKS; l++) credit_q[l] <= CRED_MAX;
            rr_ptr_q     <= '0;
            link_valid_q <= '0;
            link_tail_q  <= '0;
            link_data_q  <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            rr_ptr_q     <= rr_ptr_d;
            link_valid_q <= link_valid_d;
            link_tail_q  <= link_tail_d;
            link_data_q  <= link_data_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign link_valid = link_valid_q;
    assign link_tail  = link_tail_q;
    assign link_data  = link_data_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_lag_tile_link_scheduler.sv
// Bench for lag_tile_link_scheduler: directed vector table, hand-written
// credit/reset sequences and a randomized run against a behavioural model.
module tb_lag_tile_link_scheduler;

    localparam int NREQ    = 4;
    localparam int NLINKS  = 2;
    localparam int CREDITS = 4;
    localparam int FLIT_W  = 64;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NREQ-1:0]                req_valid;
    logic [NREQ-1:0]                req_tail;
    logic [NREQ-1:0][FLIT_W-1:0]    req_data;
    logic [NREQ-1:0]                req_ready;
    logic [NLINKS-1:0]              link_valid;
    logic [NLINKS-1:0]              link_tail;
    logic [NLINKS-1:0][FLIT_W-1:0]  link_data;
    logic [NLINKS-1:0]              credit_in;
    logic [NLINKS-1:0]              link_busy;
    logic                           credit_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lag_tile_link_scheduler #(
        .NREQ(NREQ), .NLINKS(NLINKS), .CREDITS(CREDITS), .FLIT_W(FLIT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_tail(req_tail), .req_data(req_data),
        .req_ready(req_ready),
        .link_valid(link_valid), .link_tail(link_tail), .link_data(link_data),
        .credit_in(credit_in), .link_busy(link_busy), .credit_err(credit_err)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] t;
        logic [1:0] c;
        logic [3:0] rdy;
        logic [1:0] lv;
        logic [1:0] lt;
        logic [1:0] bz;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] t,
                                input logic [1:0] c, input logic [3:0] rdy, input logic [1:0] lv,
                                input logic [1:0] lt, input logic [1:0] bz, input logic err);
        vec_t x;
        x.rst = rst; x.v = v; x.t = t; x.c = c; x.rdy = rdy;
        x.lv = lv; x.lt = lt; x.bz = bz; x.err = err;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // One clock: sample combinational ready mid-cycle, then settle after the edge.
    task automatic step(output logic [NREQ-1:0] rdy);
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [NREQ-1:0] r;
        req_valid = '0; req_tail = '0; credit_in = '0;
        rst_n = 1'b0;
        step(r);
        step(r);
        rst_n = 1'b1;
    endtask

    // Behavioural model state for the random run.
    bit                 m_busy [NLINKS];
    int                 m_own  [NLINKS];
    int                 m_cred [NLINKS];
    bit                 m_lv   [NLINKS];
    bit                 m_lt   [NLINKS];
    logic [FLIT_W-1:0]  m_ld   [NLINKS];
    int                 m_rr;
    bit                 m_err;

    task automatic model_reset();
        for (int l = 0; l < NLINKS; l++) begin
            m_busy[l] = 0; m_own[l] = 0; m_cred[l] = CREDITS;
            m_lv[l] = 0; m_lt[l] = 0; m_ld[l] = '0;
        end
        m_rr = 0;
        m_err = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] r;
        int n;

        rst_n = 1'b0;
        req_valid = '0; req_tail = '0; credit_in = '0;
        for (int s = 0; s < NREQ; s++) req_data[s] = 64'hD00D_0000_0000_0000 | 64'(s);

        // rst, valid, tail, credit_in | ready, link_valid, link_tail, link_busy, err
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'hF, 4'hF, 2'h3, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        // single source, 3-flit packet
        tbl.push_back(mk(1'b1, 4'h1, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 4'h0, 2'h0, 4'h1, 2'h1, 2'h0, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 4'h0, 2'h0, 4'h1, 2'h1, 2'h0, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 4'h1, 2'h0, 4'h1, 2'h1, 2'h1, 2'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 2'h1, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 2'h1, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 2'h1, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h0, 1'b0));
        // four sources contend for two links
        tbl.push_back(mk(1'b1, 4'hF, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h0, 2'h0, 4'h1, 2'h1, 2'h0, 2'h3, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h1, 2'h0, 4'h3, 2'h3, 2'h1, 2'h2, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h0, 2'h0, 4'h2, 2'h2, 2'h0, 2'h3, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h2, 2'h0, 4'h6, 2'h3, 2'h2, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h0, 2'h0, 4'h4, 2'h1, 2'h0, 2'h3, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h4, 2'h0, 4'h8, 2'h2, 2'h0, 2'h3, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'h4, 2'h3, 4'h0, 2'h0, 2'h0, 2'h3, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 4'hC, 2'h0, 4'hC, 2'h3, 2'h3, 2'h0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 4'h0, 2'h0, 4'h0, 2'h0, 2'h0, 2'h1, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 4'h1, 2'h0, 4'h0, 2'h0, 2'h0, 2'h1, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst; req_valid = tbl[i].v; req_tail = tbl[i].t; credit_in = tbl[i].c;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), req_ready, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_link_valid", i), link_valid, tbl[i].lv);
            chk($sformatf("vec%0d_link_tail", i), link_tail, tbl[i].lt);
            chk($sformatf("vec%0d_link_busy", i), link_busy, tbl[i].bz);
            chk($sformatf("vec%0d_credit_err", i), credit_err, tbl[i].err);
        end

        // credit exhaustion on a 6-flit packet
        do_reset();
        req_valid = 4'h1;
        step(r); chk("a_alloc_ready", r, 0);
        n = 0;
        for (int k = 0; k < 8; k++) begin step(r); n += int'(r[0]); end
        chk("a_accepted_before_stall", n, 4);
        chk("a_stalled_ready", r, 0);
        chk("a_busy_held", link_busy, 2'b01);
        credit_in = 2'b01; step(r); credit_in = 2'b00;
        chk("a_ready_in_credit_cycle", r, 0);
        n = 0;
        for (int k = 0; k < 4; k++) begin step(r); n += int'(r[0]); end
        chk("a_one_flit_released", n, 1);
        credit_in = 2'b01; step(r); credit_in = 2'b00;
        req_tail = 4'h1;
        step(r);
        chk("a_tail_ready", r, 1);
        chk("a_tail_out", link_tail, 2'b01);
        chk("a_link_freed", link_busy, 2'b00);
        req_valid = '0; req_tail = '0;

        // transfer and credit return in the same cycle
        do_reset();
        req_valid = 4'h1;
        step(r);
        step(r); chk("b_flit1", r, 1);
        step(r); chk("b_flit2", r, 1);
        credit_in = 2'b01; step(r); credit_in = 2'b00;
        chk("b_flit3_with_credit", r, 1);
        n = 0;
        for (int k = 0; k < 6; k++) begin step(r); n += int'(r[0]); end
        chk("b_credit_unchanged", n, 2);
        req_valid = '0;

        // credit overflow
        do_reset();
        credit_in = 2'b01; step(r); credit_in = 2'b00;
        chk("c_err_set", credit_err, 1);
        for (int k = 0; k < 3; k++) step(r);
        chk("c_err_sticky", credit_err, 1);
        req_valid = 4'h1;
        step(r);
        n = 0;
        for (int k = 0; k < 7; k++) begin step(r); n += int'(r[0]); end
        chk("c_credit_capped", n, 4);
        rst_n = 1'b0; step(r); rst_n = 1'b1;
        chk("c_ready_in_reset", r, 0);
        chk("c_err_cleared", credit_err, 0);
        req_valid = '0;

        // reset mid-packet
        do_reset();
        req_valid = 4'h1;
        step(r);
        step(r); chk("d_flit1", r, 1);
        step(r); chk("d_flit2", r, 1);
        rst_n = 1'b0; step(r); rst_n = 1'b1;
        chk("d_ready_in_reset", r, 0);
        chk("d_valid_after_reset", link_valid, 0);
        chk("d_busy_after_reset", link_busy, 0);
        req_valid = '0;
        n = 0;
        for (int k = 0; k < 3; k++) begin step(r); n += int'(link_valid[0]); end
        chk("d_no_further_flits", n, 0);
        req_valid = 4'h1;
        step(r); chk("d_realloc_ready", r, 0);
        n = 0;
        for (int k = 0; k < 6; k++) begin step(r); n += int'(r[0]); end
        chk("d_credit_restored", n, 4);
        req_valid = '0;

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [NREQ-1:0]   exp_rdy;
            bit                xf [NLINKS];
            bit                owned [NREQ];
            logic [NLINKS-1:0] e_lv, e_lt, e_bz;
            int                w, fl;

            rst_n = ($urandom_range(0, 99) != 0);
            for (int s = 0; s < NREQ; s++) begin
                req_valid[s] = ($urandom_range(0, 3) != 0);
                req_tail[s]  = ($urandom_range(0, 3) == 0);
                req_data[s]  = {$urandom, $urandom};
            end
            for (int l = 0; l < NLINKS; l++)
                credit_in[l] = (m_cred[l] < CREDITS) ? ($urandom_range(0, 2) == 0)
                                                     : ($urandom_range(0, 59) == 0);

            exp_rdy = '0;
            for (int s = 0; s < NREQ; s++) owned[s] = 0;
            for (int l = 0; l < NLINKS; l++) begin
                xf[l] = rst_n && m_busy[l] && (m_cred[l] > 0) && req_valid[m_own[l]];
                if (xf[l]) exp_rdy[m_own[l]] = 1'b1;
                if (m_busy[l]) owned[m_own[l]] = 1;
            end

            @(negedge clk);
            chk($sformatf("rnd%0d_ready", cyc), req_ready, exp_rdy);

            if (!rst_n) begin
                model_reset();
            end else begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int s;
                    s = (m_rr + k) % NREQ;
                    if (w < 0 && req_valid[s] && !owned[s]) w = s;
                end
                fl = -1;
                for (int l = 0; l < NLINKS; l++) if (fl < 0 && !m_busy[l]) fl = l;
                for (int l = 0; l < NLINKS; l++) begin
                    m_lv[l] = xf[l];
                    m_lt[l] = xf[l] && req_tail[m_own[l]];
                    if (xf[l]) m_ld[l] = req_data[m_own[l]];
                    if (xf[l] && !credit_in[l]) m_cred[l]--;
                    else if (!xf[l] && credit_in[l]) begin
                        if (m_cred[l] == CREDITS) m_err = 1;
                        else m_cred[l]++;
                    end
                    if (xf[l] && req_tail[m_own[l]]) m_busy[l] = 0;
                end
                if (w >= 0 && fl >= 0) begin
                    m_busy[fl] = 1;
                    m_own[fl] = w;
                    m_rr = (w + 1) % NREQ;
                end
            end

            @(posedge clk);
            #1;
            for (int l = 0; l < NLINKS; l++) begin
                e_lv[l] = m_lv[l]; e_lt[l] = m_lt[l]; e_bz[l] = m_busy[l];
                if (m_lv[l])
                    chk($sformatf("rnd%0d_data%0d", cyc, l), link_data[l], m_ld[l]);
            end
            chk($sformatf("rnd%0d_link_valid", cyc), link_valid, e_lv);
            chk($sformatf("rnd%0d_link_tail", cyc), link_tail, e_lt);
            chk($sformatf("rnd%0d_link_busy", cyc), link_busy, e_bz);
            chk($sformatf("rnd%0d_credit_err", cyc), credit_err, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
